fft_stage_sequencer: RTL and testbench

//  Sequences one in-place radix-2 DIT FFT over the mixed-precision butterfly datapath.
//  For every stage and butterfly it generates the operand-pair addresses, the twiddle
//  ROM index and that stage's multiply/add precision selects (FP4/FP8).
//  It tracks the butterfly pipeline to produce write-back strobes, and holds off the

---
 rtl/fft_stage_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issues the butterflies of an in-place radix-2 DIT FFT, one stage
// at a time. For each butterfly it drives the operand addresses, the twiddle index and
// the precision selects. A delay line that matches the butterfly latency produces the
// write-back strobes. A new stage is only started once the previous stage has fully
// written back.
module fft_stage_sequencer #(
   parameter int N_LOG2     = 3,
   parameter int BF_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [2*N_LOG2-1:0]      prec_cfg,
   output logic                     busy,
   output logic                     done,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [N_LOG2-1:0]        addr_a,
   output logic [N_LOG2-1:0]        addr_b,
   output logic [N_LOG2-2:0]        tw_addr,
   output logic [$clog2(N_LOG2):0]  stage_idx,
   output logic                     mult_prec,
   output logic                     add_prec,
   output logic                     wb_valid,
   output logic [N_LOG2-1:0]        wb_addr_a,
   output logic [N_LOG2-1:0]        wb_addr_b
);

   localparam int K_W = N_LOG2 - 1;
   localparam int S_W = $clog2(N_LOG2) + 1;
   localparam int P_W = 2 * N_LOG2;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [S_W-1:0]    s_q, s_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [P_W-1:0]    prec_q, prec_d;

   logic [BF_LATENCY-1:0] dl_vld_q, dl_vld_d;
   logic [N_LOG2-1:0]     dl_a_q [BF_LATENCY];
   logic [N_LOG2-1:0]     dl_a_d [BF_LATENCY];
   logic [N_LOG2-1:0]     dl_b_q [BF_LATENCY];
   logic [N_LOG2-1:0]     dl_b_d [BF_LATENCY];

   logic              handshake, last_k, last_stage, pending;
   logic [K_W-1:0]    pos, tw_calc;
   logic [N_LOG2-1:0] a_calc, b_calc;
   logic              mp_calc, ap_calc;

   // Operand/twiddle address generation for butterfly k of stage s.
   // When s == K_W the shifted one falls off the K_W-bit word, so the mask becomes all
   // ones and pos is simply k, as required for the last stage.
   always_comb begin
      pos     = k_q & ((K_W'(1) << s_q) - K_W'(1));
      a_calc  = (((N_LOG2'(k_q) >> s_q) << s_q) << 1) | N_LOG2'(pos);
      b_calc  = a_calc + (N_LOG2'(1) << s_q);
      tw_calc = pos << (S_W'(K_W) - s_q);
      mp_calc = 1'b0;
      ap_calc = 1'b0;
      for (int i = 0; i < N_LOG2; i++) begin
         if (s_q == S_W'(i)) begin
            mp_calc = prec_q[2*i];
            ap_calc = prec_q[2*i+1];
         end
      end
   end

   // Status flags used by the next-state logic. "pending" is true while any entry is
   // still upstream of the write-back slot, so a stage ends in its last wb_valid cycle.
   always_comb begin
      handshake  = (state_q == ST_ISSUE) && issue_ready;
      last_k     = (k_q == {K_W{1'b1}});
      last_stage = (s_q == S_W'(N_LOG2 - 1));
      pending    = 1'b0;
      for (int i = 0; i < BF_LATENCY - 1; i++) begin
         pending = pending | dl_vld_q[i];
      end
   end

   // Next-state logic, including the stage/butterfly counters and the latched config.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      prec_d  = prec_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               s_d     = '0;
               k_d     = '0;
               prec_d  = prec_cfg;
            end
         end
         ST_ISSUE: begin
            if (handshake) begin
               k_d = k_q + K_W'(1);
               if (last_k) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!pending) begin
               if (last_stage) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
                  s_d     = s_q + S_W'(1);
                  k_d     = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode; issue fields are forced to zero outside ISSUE.
   always_comb begin
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE);
      issue_valid = (state_q == ST_ISSUE);
      addr_a      = issue_valid ? a_calc : '0;
      addr_b      = issue_valid ? b_calc : '0;
      tw_addr     = issue_valid ? tw_calc : '0;
      mult_prec   = issue_valid & mp_calc;
      add_prec    = issue_valid & ap_calc;
      stage_idx   = busy ? s_q : '0;
      wb_valid    = dl_vld_q[BF_LATENCY-1];
      wb_addr_a   = dl_a_q[BF_LATENCY-1];
      wb_addr_b   = dl_b_q[BF_LATENCY-1];
   end

   // Write-back delay line. Address fields advance only behind a valid entry, so the
   // final slot keeps the last written addresses while idle.
   always_comb begin
      dl_vld_d[0] = handshake;
      dl_a_d[0]   = handshake ? a_calc : dl_a_q[0];
      dl_b_d[0]   = handshake ? b_calc : dl_b_q[0];
      for (int i = 1; i < BF_LATENCY; i++) begin
         dl_vld_d[i] = dl_vld_q[i-1];
         dl_a_d[i]   = dl_vld_q[i-1] ? dl_a_q[i-1] : dl_a_q[i];
         dl_b_d[i]   = dl_vld_q[i-1] ? dl_b_q[i-1] : dl_b_q[i];
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         k_q     <= '0;
         prec_q  <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
         prec_q  <= prec_d;
      end
   end

   // Delay-line registers; cleared on reset so an aborted run emits no further writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_vld_q <= '0;
         for (int i = 0; i < BF_LATENCY; i++) begin
            dl_a_q[i] <= '0;
            dl_b_q[i] <= '0;
         end
      end else begin
         dl_vld_q <= dl_vld_d;
         for (int i = 0; i < BF_LATENCY; i++) begin
            dl_a_q[i] <= dl_a_d[i];
            dl_b_q[i] <= dl_b_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer: an 8-point instance with latency 2 and a 16-point
// instance with latency 1. Expected issues come from a group/offset model of the
// radix-2 DIT ordering. Write-backs are checked through a scoreboard queue.
module tb_fft_stage_sequencer;

   typedef struct {
      int a;
      int b;
      int tw;
      int s;
      int mp;
      int ap;
   } iss_t;

   typedef struct {
      int a;
      int b;
      int cyc;
   } wb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic rst_n;

   // 8-point instance, latency 2
   logic       start0, ready0;
   logic [5:0] prec0;
   logic       busy0, done0, iv0, mp0, ap0, wbv0;
   logic [2:0] aa0, ab0, wa0, wb0, st0;
   logic [1:0] tw0;

   // 16-point instance, latency 1
   logic       start1, ready1;
   logic [7:0] prec1;
   logic       busy1, done1, iv1, mp1, ap1, wbv1;
   logic [3:0] aa1, ab1, wa1, wb1;
   logic [2:0] tw1, st1;

   iss_t exp_iss[$];
   wb_t  sb[$];

   fft_stage_sequencer #(.N_LOG2(3), .BF_LATENCY(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .prec_cfg(prec0),
      .busy(busy0), .done(done0), .issue_valid(iv0), .issue_ready(ready0),
      .addr_a(aa0), .addr_b(ab0), .tw_addr(tw0), .stage_idx(st0),
      .mult_prec(mp0), .add_prec(ap0), .wb_valid(wbv0),
      .wb_addr_a(wa0), .wb_addr_b(wb0)
   );

   fft_stage_sequencer #(.N_LOG2(4), .BF_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .prec_cfg(prec1),
      .busy(busy1), .done(done1), .issue_valid(iv1), .issue_ready(ready1),
      .addr_a(aa1), .addr_b(ab1), .tw_addr(tw1), .stage_idx(st1),
      .mult_prec(mp1), .add_prec(ap1), .wb_valid(wbv1),
      .wb_addr_a(wa1), .wb_addr_b(wb1)
   );

   // Expected issue order: group g of 2*half entries, offset j inside the group.
   task automatic build_expect(input int nlog2, input logic [7:0] pcfg);
      int half, nn;
      exp_iss.delete();
      sb.delete();
      nn = 1 << nlog2;
      for (int s = 0; s < nlog2; s++) begin
         half = 1 << s;
         for (int g = 0; g < nn / (2 * half); g++) begin
            for (int j = 0; j < half; j++) begin
               exp_iss.push_back('{g * 2 * half + j, g * 2 * half + j + half,
                                   j * ((nn / 2) / half), s,
                                   int'(pcfg[2*s]), int'(pcfg[2*s+1])});
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start0 = 1'b0; ready0 = 1'b0; prec0 = '0;
      start1 = 1'b0; ready1 = 1'b0; prec1 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy0, done0, iv0, aa0, ab0, tw0, st0, mp0, ap0, wbv0, wa0, wb0} !== '0) begin
         failures++;
         $display("FAIL reset_outputs0 got busy=%b done=%b iv=%b a=%0d b=%0d wbv=%b", busy0, done0, iv0, aa0, ab0, wbv0);
      end
      checks++;
      if ({busy1, done1, iv1, aa1, ab1, tw1, st1, mp1, ap1, wbv1, wa1, wb1} !== '0) begin
         failures++;
         $display("FAIL reset_outputs1 got busy=%b done=%b iv=%b a=%0d b=%0d wbv=%b", busy1, done1, iv1, aa1, ab1, wbv1);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One full 8-point transform. rnd randomises issue_ready; disturb changes prec_cfg
   // and pulses start while the transform is busy.
   task automatic run0(input logic [5:0] pcfg, input bit rnd, input bit disturb);
      iss_t e;
      wb_t  w;
      int   last_wb, n_wb, n_done, last_s;
      bit   prev_stall;
      logic [2:0] pa, pb, ps;
      logic [1:0] ptw;
      logic pmp, pap;
      build_expect(3, {2'b00, pcfg});
      prec0 = pcfg; start0 = 1'b1; ready0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      checks++;
      if (busy0 !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_start got %b want 1", busy0);
      end
      last_wb = -100; n_wb = 0; n_done = 0; last_s = 0; prev_stall = 0;
      pa = '0; pb = '0; ps = '0; ptw = '0; pmp = 1'b0; pap = 1'b0;
      for (int t = 0; t < 400 && n_done == 0; t++) begin
         if (disturb && t == 3) begin prec0 = ~pcfg; start0 = 1'b1; end
         if (disturb && t == 4) start0 = 1'b0;
         if (wbv0) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL wb_unexpected got a=%0d b=%0d at cycle %0d", wa0, wb0, cyc);
            end else begin
               w = sb.pop_front();
               if (wa0 !== w.a || wb0 !== w.b || cyc != w.cyc + 2) begin
                  failures++;
                  $display("FAIL wb_match got (%0d,%0d)@%0d want (%0d,%0d)@%0d", wa0, wb0, cyc, w.a, w.b, w.cyc + 2);
               end
            end
            n_wb++;
            last_wb = cyc;
         end
         if (iv0) begin
            if (exp_iss.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_issue got a=%0d b=%0d", aa0, ab0);
            end else begin
               e = exp_iss[0];
               checks++;
               if (aa0 !== e.a || ab0 !== e.b || tw0 !== e.tw || st0 !== e.s || mp0 !== e.mp || ap0 !== e.ap) begin
                  failures++;
                  $display("FAIL issue got a=%0d b=%0d tw=%0d s=%0d mp=%b ap=%b want a=%0d b=%0d tw=%0d s=%0d mp=%0d ap=%0d",
                           aa0, ab0, tw0, st0, mp0, ap0, e.a, e.b, e.tw, e.s, e.mp, e.ap);
               end
               if (prev_stall) begin
                  checks++;
                  if (aa0 !== pa || ab0 !== pb || tw0 !== ptw || st0 !== ps || mp0 !== pmp || ap0 !== pap) begin
                     failures++;
                     $display("FAIL issue_hold got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d", aa0, ab0, tw0, pa, pb, ptw);
                  end
               end
               if (e.s != last_s) begin
                  checks++;
                  if (cyc != last_wb + 1) begin
                     failures++;
                     $display("FAIL stage_start got cycle %0d want %0d", cyc, last_wb + 1);
                  end
                  last_s = e.s;
               end
               ready0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               pa = aa0; pb = ab0; ptw = tw0; ps = st0; pmp = mp0; pap = ap0;
               prev_stall = !ready0;
               if (ready0) begin
                  void'(exp_iss.pop_front());
                  sb.push_back('{e.a, e.b, cyc});
               end
            end
         end else begin
            prev_stall = 0;
         end
         if (done0) begin
            n_done++;
            checks++;
            if (cyc != last_wb + 1 || n_wb != 12) begin
               failures++;
               $display("FAIL done_timing got cycle %0d wbs %0d want cycle %0d wbs 12", cyc, n_wb, last_wb + 1);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (n_done != 1 || exp_iss.size() != 0 || sb.size() != 0) begin
         failures++;
         $display("FAIL run_complete got done=%0d left_iss=%0d left_wb=%0d want 1 0 0", n_done, exp_iss.size(), sb.size());
      end
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (done0 !== 1'b0 || busy0 !== 1'b0 || iv0 !== 1'b0 || wbv0 !== 1'b0) begin
            failures++;
            $display("FAIL post_done got done=%b busy=%b iv=%b wbv=%b want 0 0 0 0", done0, busy0, iv0, wbv0);
         end
         @(negedge clk);
      end
      start0 = 1'b0;
   endtask

   task automatic test_basic();
      run0(6'b00_00_00, 1'b0, 1'b0);
   endtask

   task automatic test_precision();
      run0(6'b10_01_11, 1'b0, 1'b1);
   endtask

   task automatic test_random_ready();
      run0(6'b01_10_11, 1'b1, 1'b0);
   endtask

   task automatic test_reset_midrun();
      int t;
      prec0 = '0; start0 = 1'b1; ready0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (t = 0; t < 50 && !(iv0 && st0 == 3'd1); t++) @(negedge clk);
      checks++;
      if (!(iv0 && st0 == 3'd1)) begin
         failures++;
         $display("FAIL reach_stage1 got iv=%b s=%0d want 1 1", iv0, st0);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy0, done0, iv0, aa0, ab0, tw0, st0, mp0, ap0, wbv0, wa0, wb0} !== '0) begin
         failures++;
         $display("FAIL async_reset got busy=%b iv=%b a=%0d b=%0d wbv=%b wa=%0d wb=%0d", busy0, iv0, aa0, ab0, wbv0, wa0, wb0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done0 !== 1'b0 || wbv0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got done=%b wbv=%b busy=%b want 0 0 0", done0, wbv0, busy0);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      run0(6'b11_00_10, 1'b0, 1'b0);
   endtask

   task automatic test_n16();
      iss_t e;
      wb_t  w;
      int   last_wb, n_wb, n_done, n_iss;
      build_expect(4, 8'hB4);
      prec1 = 8'hB4; start1 = 1'b1; ready1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      last_wb = -100; n_wb = 0; n_done = 0; n_iss = 0;
      for (int t = 0; t < 400 && n_done == 0; t++) begin
         if (wbv1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL wb16_unexpected got a=%0d b=%0d", wa1, wb1);
            end else begin
               w = sb.pop_front();
               if (wa1 !== w.a || wb1 !== w.b || cyc != w.cyc + 1) begin
                  failures++;
                  $display("FAIL wb16_match got (%0d,%0d)@%0d want (%0d,%0d)@%0d", wa1, wb1, cyc, w.a, w.b, w.cyc + 1);
               end
            end
            n_wb++;
            last_wb = cyc;
         end
         if (iv1) begin
            checks++;
            if (exp_iss.size() == 0) begin
               failures++;
               $display("FAIL extra_issue16 got a=%0d b=%0d", aa1, ab1);
            end else begin
               e = exp_iss.pop_front();
               if (aa1 !== e.a || ab1 !== e.b || tw1 !== e.tw || st1 !== e.s || mp1 !== e.mp || ap1 !== e.ap) begin
                  failures++;
                  $display("FAIL issue16 got a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                           aa1, ab1, tw1, st1, e.a, e.b, e.tw, e.s);
               end
               sb.push_back('{e.a, e.b, cyc});
               n_iss++;
            end
         end
         if (done1) begin
            n_done++;
            checks++;
            if (cyc != last_wb + 1 || n_wb != 32 || n_iss != 32) begin
               failures++;
               $display("FAIL done16 got cycle %0d wbs %0d issues %0d want cycle %0d 32 32", cyc, n_wb, n_iss, last_wb + 1);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (n_done != 1 || exp_iss.size() != 0 || sb.size() != 0) begin
         failures++;
         $display("FAIL run16_complete got done=%0d left_iss=%0d left_wb=%0d want 1 0 0", n_done, exp_iss.size(), sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_precision();
      test_random_ready();
      test_reset_midrun();
      test_n16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
